// File: rtl/alu_sequencer.sv
// Issuing end of the 8-bit ALU interface: register file, carry flag and a four-state
// sequencer that drives one accepted instruction through READ, EXEC and WB.
module alu_sequencer #(
  parameter int unsigned NREG = 8,
  parameter int unsigned W    = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_instr_valid,
  output logic         o_instr_ready,
  input  logic [12:0]  i_instr,
  input  logic         i_wr_en,
  input  logic [2:0]   i_wr_addr,
  input  logic [W-1:0] i_wr_data,
  input  logic [2:0]   i_rd_addr,
  output logic [W-1:0] o_rd_data,
  output logic [W-1:0] o_alu_in1,
  output logic [W-1:0] o_alu_in2,
  output logic         o_alu_cin,
  output logic [2:0]   o_alu_func,
  input  logic [W-1:0] i_alu_result,
  input  logic         i_alu_cout,
  output logic         o_carry,
  output logic         o_done,
  output logic [2:0]   o_done_rd,
  output logic [W-1:0] o_done_data
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic [12:0]  r_instr;
  logic [W-1:0] r_regs [NREG];
  logic         r_carry;
  logic [W-1:0] r_alu_in1;
  logic [W-1:0] r_alu_in2;
  logic         r_alu_cin;
  logic [2:0]   r_alu_func;
  logic [W-1:0] r_res;
  logic         r_cout;

  logic         w_accept;
  logic         w_wb;
  logic         w_use_cin;
  logic [2:0]   w_func;
  logic [2:0]   w_rd;
  logic [2:0]   w_rs1;
  logic [2:0]   w_rs2;
  logic         w_host_wr;

  assign w_use_cin = r_instr[12];
  assign w_func    = r_instr[11:9];
  assign w_rd      = r_instr[8:6];
  assign w_rs1     = r_instr[5:3];
  assign w_rs2     = r_instr[2:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    o_instr_ready = 1'b0;
    w_wb          = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) begin
          w_state_next = StRead;
        end
      end
      StRead: w_state_next = StExec;
      StExec: w_state_next = StWb;
      StWb: begin
        w_wb         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_accept = i_instr_valid && o_instr_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= '0;
    end else if (w_accept) begin
      r_instr <= i_instr;
    end
  end

  // Operands are sampled on the edge that leaves READ, so a host write landing on that
  // same edge is not seen, while one landing on the accept edge is.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_in1  <= '0;
      r_alu_in2  <= '0;
      r_alu_cin  <= 1'b0;
      r_alu_func <= '0;
    end else if (r_state == StRead) begin
      r_alu_in1  <= r_regs[w_rs1];
      r_alu_in2  <= r_regs[w_rs2];
      r_alu_cin  <= w_use_cin ? r_carry : 1'b0;
      r_alu_func <= w_func;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res  <= '0;
      r_cout <= 1'b0;
    end else if (r_state == StExec) begin
      r_res  <= i_alu_result;
      r_cout <= i_alu_cout;
    end
  end

  // Writeback owns the destination register in WB; a host write to the same address loses.
  assign w_host_wr = i_wr_en && !(w_wb && (i_wr_addr == w_rd));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_host_wr) begin
        r_regs[i_wr_addr] <= i_wr_data;
      end
      if (w_wb) begin
        r_regs[w_rd] <= r_res;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_carry <= 1'b0;
    end else if (w_wb) begin
      r_carry <= r_cout;
    end
  end

  assign o_rd_data   = r_regs[i_rd_addr];
  assign o_alu_in1   = r_alu_in1;
  assign o_alu_in2   = r_alu_in2;
  assign o_alu_cin   = r_alu_cin;
  assign o_alu_func  = r_alu_func;
  assign o_carry     = r_carry;
  assign o_done      = w_wb;
  assign o_done_rd   = w_wb ? w_rd : 3'd0;
  assign o_done_data = w_wb ? r_res : '0;

endmodule
